cla_subtractor_pipe: RTL and testbench
======================================

// Module: cla_subtractor_pipe
// PURPOSE
//   32-bit two's-complement subtractor D = A - B - Bin, built as the borrow-side
//   counterpart of the CLA adder: 8 blocks of 4 bits, block borrow-generate/propagate, lookahead borrow.
//   Two-stage pipeline with valid/ready handshake on both sides; sits beside the adder in the ALU datapath.
// PARAMETERS
//   WIDTH       32  operand width; must equal NUM_BLOCKS*BLOCK_W
//   BLOCK_W     4   bits per lookahead block (fixed, from cla_pkg)
//   NUM_BLOCKS  8   number of lookahead blocks (from cla_pkg)
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      A/B/Bin valid this cycle
//   in_ready   out  1      block accepts operands when in_valid & in_ready
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   Bin        in   1      borrow in (1 = subtract one more)
//   out_valid  out  1      D and flags valid
//   out_ready  in   1      consumer takes result when out_valid & out_ready
//   D          out  WIDTH  difference, modulo 2^WIDTH
//   Bout       out  1      borrow out (1 = unsigned A < B+Bin)
//   V          out  1      signed overflow
//   Z          out  1      D == 0
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): s1_valid, s2_valid, out_valid = 0; D, Bout, V, Z = 0.
//   Reset mid-operation discards both in-flight results; no output produced for them.
// - Bit level: g = ~a & b, p = ~(a ^ b); d = a ^ b ^ bin; bout = g | (p & bin).
// - Block k: G = g3 | p3g2 | p3p2g1 | p3p2p1g0; P = p3&p2&p1&p0;
//   borrow[k+1] = G[k] | (P[k] & borrow[k]); borrow[0] = Bin; Bout = borrow[8].
// - Stage 1 (on accept): register A, B, Bin, G[7:0], P[7:0]; s1_valid <= 1.
// - Stage 2: resolve borrow[8:0] from registered G/P, compute per-block differences,
//   register D, Bout, V = (A[31]^B[31]) & (D[31]^A[31]), Z; s2_valid <= 1.
// - Latency: exactly 2 cycles accept -> out_valid when out_ready held high.
// - Throughput 1/cycle. s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv;
//   in_ready = s1_adv (combinational, no dependency on in_valid).
// - Stall: out_valid & ~out_ready holds D/flags stable; stage 1 holds if also full.
//   Both stages full and stalled -> in_ready = 0; no operand lost or duplicated.
// - Simultaneous accept and drain in a full pipe: both stages advance same cycle.
// - Registers update only when their stage advances; out_valid drops to 0 after a take
//   with no new stage-1 data.
// - Wrap-around: 0 - 1 -> D = 32'hFFFF_FFFF, Bout = 1; result always modulo 2^32.
// STRUCTURE
// - cla_pkg: BLOCK_W, NUM_BLOCKS, WIDTH localparams; block_gp_t struct {G, P}.
// - Sub-module four_bit_rbs: 4-bit ripple-borrow subtractor (a, b, bin -> d, bout),
//   instantiated NUM_BLOCKS times in stage 2 via generate; its bout left unused.
// - Block G/P logic in stage 1 via generate loop; handshake in a small always block.
// TESTING
// - 5 - 3, Bin=0, out_ready=1 -> after 2 cycles D=2, Bout=0, V=0, Z=0.
// - 0 - 1, Bin=0 -> D=32'hFFFF_FFFF, Bout=1, V=0; 7 - 7, Bin=0 -> D=0, Z=1.
// - 32'h8000_0000 - 1 -> D=32'h7FFF_FFFF, V=1, Bout=0; 32'h7FFF_FFFF - 32'hFFFF_FFFF -> V=1, Bout=1.
// - Borrow ripple: 32'h0000_0000 - 0, Bin=1 -> D=32'hFFFF_FFFF, Bout=1 (borrow crosses all 8 blocks).
// - Back-pressure: stream 4 ops, out_ready low 3 cycles -> in_ready=0 after 2 accepts,
//   results emerge in order, none lost or duplicated; 1/cycle once out_ready high.
// - Reset with both stages full -> next cycle out_valid=0, D=0, in_ready=1.

Source files
------------

// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the carry/borrow lookahead arithmetic blocks.
//   BLOCK_W     bits per lookahead block
//   NUM_BLOCKS  number of lookahead blocks across the operand
//   WIDTH       operand width (BLOCK_W * NUM_BLOCKS)
//   block_gp_t  block-level borrow generate / propagate pair
//   block_gp()  reduces one 4-bit slice of A and B to its block G/P pair
// ----------------------------------------------------------------------------
package cla_pkg;

    localparam int BLOCK_W    = 4;
    localparam int NUM_BLOCKS = 8;
    localparam int WIDTH      = BLOCK_W * NUM_BLOCKS;

    typedef struct packed {
        logic G;
        logic P;
    } block_gp_t;

    // Borrow generate: the slice produces a borrow on its own.
    // Borrow propagate: an incoming borrow passes straight through.
    function automatic block_gp_t block_gp(input logic [BLOCK_W-1:0] a,
                                           input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] g;
        logic [BLOCK_W-1:0] p;
        block_gp_t          r;
        g   = ~a & b;
        p   = ~(a ^ b);
        r.G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.P = &p;
        return r;
    endfunction

endpackage

// File: rtl/four_bit_rbs.sv
// ----------------------------------------------------------------------------
// four_bit_rbs
// 4-bit ripple-borrow subtractor: d = a - b - bin.
//   a, b   in   4  minuend / subtrahend slice
//   bin    in   1  borrow into bit 0
//   d      out  4  difference slice
//   bout   out  1  borrow out of bit 3
// ----------------------------------------------------------------------------
module four_bit_rbs
    import cla_pkg::*;
(
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               bin,
    output logic [BLOCK_W-1:0] d,
    output logic               bout
);

    logic [BLOCK_W:0] bw;

    always_comb begin
        bw    = '0;
        d     = '0;
        bw[0] = bin;
        for (int i = 0; i < BLOCK_W; i++) begin
            d[i]    = a[i] ^ b[i] ^ bw[i];
            bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
    end

    assign bout = bw[BLOCK_W];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// ----------------------------------------------------------------------------
// cla_subtractor_pipe
// Two-stage pipelined 32-bit lookahead-borrow subtractor: D = A - B - Bin.
// Stage 1 reduces each 4-bit block to a borrow G/P pair; stage 2 resolves the
// block borrows and forms the difference and flags. valid/ready on both sides.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (A, B, Bin)
//   out_valid/out_ready result handshake (D, Bout, V, Z)
//   D     difference modulo 2^WIDTH
//   Bout  borrow out (unsigned A < B + Bin)
//   V     signed overflow
//   Z     D == 0
// ----------------------------------------------------------------------------
module cla_subtractor_pipe
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    // Handshake: a stage may advance when it is empty or its consumer advances.
    always_comb begin
        s2_adv   = ~s2_valid | out_ready;
        s1_adv   = ~s1_valid | s2_adv;
        in_ready = s1_adv;
        accept   = in_valid & s1_adv;
    end

    // ---------------- stage 1: block borrow generate / propagate ----------------
    block_gp_t [NUM_BLOCKS-1:0] gp_p0;

    genvar k;
    generate
        for (k = 0; k < NUM_BLOCKS; k++) begin : g_blk_gp
            assign gp_p0[k] = block_gp(A[k*BLOCK_W +: BLOCK_W], B[k*BLOCK_W +: BLOCK_W]);
        end
    endgenerate

    logic [WIDTH-1:0]           a_p1;
    logic [WIDTH-1:0]           b_p1;
    logic                       bin_p1;
    block_gp_t [NUM_BLOCKS-1:0] gp_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1   <= A;
            b_p1   <= B;
            bin_p1 <= Bin;
            gp_p1  <= gp_p0;
        end
    end

    // ---------------- stage 2: lookahead borrow resolve, difference, flags ----------------
    logic [NUM_BLOCKS:0]    borrow;
    logic [WIDTH-1:0]       d_p1;
    logic [NUM_BLOCKS-1:0]  rbs_bout_unused;
    logic                   v_p1;

    always_comb begin
        borrow    = '0;
        borrow[0] = bin_p1;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            borrow[i+1] = gp_p1[i].G | (gp_p1[i].P & borrow[i]);
        end
    end

    // Each block ripples internally from its lookahead borrow-in; the block's own
    // borrow-out is redundant with borrow[k+1] and is not used.
    generate
        for (k = 0; k < NUM_BLOCKS; k++) begin : g_blk_sub
            four_bit_rbs u_rbs (
                .a    (a_p1[k*BLOCK_W +: BLOCK_W]),
                .b    (b_p1[k*BLOCK_W +: BLOCK_W]),
                .bin  (borrow[k]),
                .d    (d_p1[k*BLOCK_W +: BLOCK_W]),
                .bout (rbs_bout_unused[k])
            );
        end
    endgenerate

    // Overflow: operands of different sign and the result sign differs from A.
    assign v_p1 = (a_p1[WIDTH-1] ^ b_p1[WIDTH-1]) & (d_p1[WIDTH-1] ^ a_p1[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            D        <= '0;
            Bout     <= 1'b0;
            V        <= 1'b0;
            Z        <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                D    <= d_p1;
                Bout <= borrow[NUM_BLOCKS];
                V    <= v_p1;
                Z    <= ~|d_p1;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// ----------------------------------------------------------------------------
// tb_cla_subtractor_pipe
// Directed bench for cla_subtractor_pipe with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_cla_subtractor_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int checks;
    int errors;

    cla_subtractor_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One operation through an idle pipe with out_ready held high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [31:0] exp_d, input logic exp_bout, input logic exp_v, input logic exp_z);
        A        = a;
        B        = b;
        Bin      = bi;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_D"},     D,                  exp_d);
        check({tag, "_Bout"},  {31'b0, Bout},      {31'b0, exp_bout});
        check({tag, "_V"},     {31'b0, V},         {31'b0, exp_v});
        check({tag, "_Z"},     {31'b0, Z},         {31'b0, exp_z});
        step();
        check({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        #1;
        step();
        step();

        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_D",         D,                  32'd0);
        check("rst_flags",     {29'b0, Bout, V, Z}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        rst_n = 1'b1;
        step();

        run_op("sub_5_3",     32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0, 1'b0);
        run_op("sub_0_1",     32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
        run_op("sub_7_7",     32'd7,          32'd7,          1'b0, 32'd0,          1'b0, 1'b0, 1'b1);
        run_op("min_minus_1", 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0);
        run_op("max_minus_m1",32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1, 1'b0);
        run_op("ripple_bin",  32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
        run_op("mixed_bin",   32'h1234_5678,  32'd1,          1'b1, 32'h1234_5676,  1'b0, 1'b0, 1'b0);

        // Back-pressure: four ops, consumer stalled for three cycles.
        out_ready = 1'b0;
        A = 32'd100; B = 32'd1; Bin = 1'b0; in_valid = 1'b1;
        check("bp_ready0", {31'b0, in_ready}, 32'd1);
        step();
        A = 32'd200; B = 32'd2;
        check("bp_ready1", {31'b0, in_ready}, 32'd1);
        step();
        A = 32'd300; B = 32'd3;
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_valid0",     {31'b0, out_valid}, 32'd1);
        check("bp_D0",         D, 32'd99);
        step();
        check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_D",     D, 32'd99);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        step();
        A = 32'd400; B = 32'd4;
        check("bp_D1", D, 32'd198);
        check("bp_valid1", {31'b0, out_valid}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_D2", D, 32'd297);
        step();
        check("bp_D3", D, 32'd396);
        check("bp_valid3", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);
        check("bp_empty_D", D, 32'd396);

        // Reset with both stages holding results.
        out_ready = 1'b0;
        A = 32'd50; B = 32'd10; in_valid = 1'b1;
        step();
        A = 32'd60;
        step();
        in_valid = 1'b0;
        check("rf_full_valid", {31'b0, out_valid}, 32'd1);
        check("rf_full_D",     D, 32'd40);
        rst_n = 1'b0;
        step();
        check("rf_valid", {31'b0, out_valid}, 32'd0);
        check("rf_D",     D, 32'd0);
        check("rf_ready", {31'b0, in_ready}, 32'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("rf_no_ghost0", {31'b0, out_valid}, 32'd0);
        step();
        check("rf_no_ghost1", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
